prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_if.sv | 33 +++
 rtl/prog_loader.sv | 121 ++++++++++++
 2 files changed

// File: rtl/prog_loader_if.sv
// prog_loader_if -- bundle of the loader's request, byte stream, RAM and
// status signals.
//   master : drives start/base_adr/len/abort and the byte stream
//            (in_byte/in_valid); observes in_ready, RAM and status signals.
//   slave  : the loader itself; drives in_ready, ram_adr/ram_wdata/ram_read,
//            busy, done and checksum.
interface prog_loader_if #(
    parameter int DEPTH_BITS = 8
);
    logic                  start;
    logic [DEPTH_BITS-1:0] base_adr;
    logic [7:0]            len;
    logic                  abort;
    logic [7:0]            in_byte;
    logic                  in_valid;
    logic                  in_ready;
    logic [DEPTH_BITS-1:0] ram_adr;
    logic [15:0]           ram_wdata;
    logic                  ram_read;
    logic                  busy;
    logic                  done;
    logic [15:0]           checksum;

    modport master (
        output start, base_adr, len, abort, in_byte, in_valid,
        input  in_ready, ram_adr, ram_wdata, ram_read, busy, done, checksum
    );

    modport slave (
        input  start, base_adr, len, abort, in_byte, in_valid,
        output in_ready, ram_adr, ram_wdata, ram_read, busy, done, checksum
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader -- assembles a byte stream (high byte first) into 16-bit words
// and writes them to consecutive RAM word addresses starting at base_adr,
// keeping a running XOR checksum of the words written.
//   clk    : rising-edge system clock
//   rst_n  : asynchronous active-low reset
//   bus    : prog_loader_if.slave -- start/base_adr/len/abort request,
//            in_byte/in_valid/in_ready byte stream, ram_adr/ram_wdata/ram_read
//            RAM port (ram_read=0 is the write strobe), busy/done/checksum.
module prog_loader #(
    parameter int DEPTH_BITS = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    prog_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        HI,
        LO,
        WRITE,
        DONE
    } state_t;

    state_t                state_q,   state_nxt;
    logic [DEPTH_BITS-1:0] adr_q,     adr_nxt;
    logic [15:0]           wdata_q,   wdata_nxt;
    logic [15:0]           cs_q,      cs_nxt;
    logic [7:0]            rem_q,     rem_nxt;
    logic                  in_ready_w;
    logic                  xfer;

    assign in_ready_w = (state_q == HI) || (state_q == LO);
    assign xfer       = bus.in_valid && in_ready_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            adr_q   <= '0;
            wdata_q <= '0;
            cs_q    <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_nxt;
            adr_q   <= adr_nxt;
            wdata_q <= wdata_nxt;
            cs_q    <= cs_nxt;
            rem_q   <= rem_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        adr_nxt   = adr_q;
        wdata_nxt = wdata_q;
        cs_nxt    = cs_q;
        rem_nxt   = rem_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cs_nxt = '0;
                    if (bus.len != 8'd0) begin
                        adr_nxt   = bus.base_adr;
                        rem_nxt   = bus.len;
                        state_nxt = HI;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            HI: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (xfer) begin
                    wdata_nxt[15:8] = bus.in_byte;
                    state_nxt       = LO;
                end
            end
            LO: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (xfer) begin
                    wdata_nxt[7:0] = bus.in_byte;
                    state_nxt      = WRITE;
                end
            end
            WRITE: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else begin
                    cs_nxt  = cs_q ^ wdata_q;
                    rem_nxt = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        state_nxt = DONE;
                    end else begin
                        adr_nxt   = adr_q + DEPTH_BITS'(1);
                        state_nxt = HI;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // An abort arriving during WRITE suppresses the strobe in that same cycle,
    // so ram_read looks at abort as well as the state.
    assign bus.ram_read  = !((state_q == WRITE) && !bus.abort);
    assign bus.in_ready  = in_ready_w;
    assign bus.busy      = (state_q == HI) || (state_q == LO) || (state_q == WRITE);
    assign bus.done      = (state_q == DONE);
    assign bus.ram_adr   = adr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.checksum  = cs_q;

endmodule
